// File: rtl/rv_core_pkg.sv
// Shared core constants and the writeback request payload.
package rv_core_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned NREG = 32;

    typedef struct packed {
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/rf_wb_arb.sv
// NREQ-way one-hot arbiter for the register-file write port.
// RF_WB_RR_EN selects round-robin (with a pointer); otherwise fixed priority, lowest index wins.
module rf_wb_arb #(
    parameter int unsigned NREQ = 2
) (
`ifdef RF_WB_RR_EN
    input  logic            clk,
    input  logic            rst_n,
`endif
    input  logic [NREQ-1:0] valid,
    output logic [NREQ-1:0] grant_c
);

`ifdef RF_WB_RR_EN
    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_nxt_c;

    // Search starting at the pointer; the pointer moves past the winner.
    always_comb begin
        int   idx;
        logic found;
        grant_c   = '0;
        ptr_nxt_c = ptr;
        idx       = 0;
        found     = 1'b0;
        for (int k = 0; k < int'(NREQ); k++) begin
            idx = (int'(ptr) + k) % int'(NREQ);
            if (!found && valid[idx]) begin
                grant_c[idx] = 1'b1;
                ptr_nxt_c    = PW'((idx + 1) % int'(NREQ));
                found        = 1'b1;
            end
        end
    end

    // Round-robin pointer; holds when nothing is granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_nxt_c;
        end
    end
`else
    // Fixed priority: the lowest valid index is assigned last and wins.
    always_comb begin
        grant_c = '0;
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            if (valid[i]) begin
                grant_c = NREQ'(1) << i;
            end
        end
    end
`endif

endmodule

// File: rtl/rf_wb_scheduler.sv
// Writeback scheduler: shares reg_file's single write port among NREQ units
// and tracks pending destination writes for RAW hazard detection.
// Optional macro RF_WB_RR_EN: round-robin arbitration instead of fixed priority.
module rf_wb_scheduler #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned XLEN = 32,
    parameter int unsigned AW   = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*XLEN-1:0] req_data,
    input  logic                 rsv_valid,
    input  logic [AW-1:0]        rsv_addr,
    input  logic [AW-1:0]        q_a1,
    input  logic [AW-1:0]        q_a2,
    output logic                 q_busy1,
    output logic                 q_busy2,
    output logic [31:0]          busy,
    output logic                 we3,
    output logic [AW-1:0]        a3,
    output logic [XLEN-1:0]      wd3
);

    import rv_core_pkg::*;

    logic [NREQ-1:0] grant_c;
    logic [NREQ-1:0] hs_c;
    logic            hs_any_c;
    wb_req_t         sel_c;
    logic [NREG-1:0] busy_nxt_c;

    rf_wb_arb #(.NREQ(NREQ)) u_arb (
`ifdef RF_WB_RR_EN
        .clk     (clk),
        .rst_n   (rst_n),
`endif
        .valid   (req_valid),
        .grant_c (grant_c)
    );

    // Nothing is accepted while reset is asserted.
    assign req_ready = grant_c & {NREQ{rst_n}};
    assign hs_c      = req_valid & req_ready;
    assign hs_any_c  = |hs_c;

    // Select the payload of the (single) handshaking requester.
    always_comb begin
        sel_c = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (hs_c[i]) begin
                sel_c.addr = req_addr[i*AW +: AW];
                sel_c.data = req_data[i*XLEN +: XLEN];
            end
        end
    end

    // Scoreboard next state: clear on writeback, then set on reserve so a new owner wins.
    always_comb begin
        busy_nxt_c = busy;
        if (hs_any_c && (sel_c.addr != '0)) begin
            busy_nxt_c[sel_c.addr] = 1'b0;
        end
        if (rsv_valid && (rsv_addr != '0)) begin
            busy_nxt_c[rsv_addr] = 1'b1;
        end
        busy_nxt_c[0] = 1'b0;
    end

    // Registered write port; x0 writes are swallowed and a3/wd3 hold when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we3 <= 1'b0;
            a3  <= '0;
            wd3 <= '0;
        end else if (hs_any_c && (sel_c.addr != '0)) begin
            we3 <= 1'b1;
            a3  <= sel_c.addr;
            wd3 <= sel_c.data;
        end else begin
            we3 <= 1'b0;
        end
    end

    // Pending-write scoreboard register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt_c;
        end
    end

    assign q_busy1 = busy[q_a1];
    assign q_busy2 = busy[q_a2];

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Directed self-checking bench for rf_wb_scheduler (NREQ=2).
module tb_rf_wb_scheduler;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [9:0]  req_addr;
    logic [63:0] req_data;
    logic        rsv_valid;
    logic [4:0]  rsv_addr;
    logic [4:0]  q_a1;
    logic [4:0]  q_a2;
    logic        q_busy1;
    logic        q_busy2;
    logic [31:0] busy;
    logic        we3;
    logic [4:0]  a3;
    logic [31:0] wd3;

    int checks;
    int failures;

    rf_wb_scheduler #(.NREQ(2), .XLEN(32), .AW(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .q_a1      (q_a1),
        .q_a2      (q_a2),
        .q_busy1   (q_busy1),
        .q_busy2   (q_busy2),
        .busy      (busy),
        .we3       (we3),
        .a3        (a3),
        .wd3       (wd3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  v;
        logic [4:0]  a0;
        logic [4:0]  a1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        rv;
        logic [4:0]  ra;
        logic [4:0]  q1a;
        logic [4:0]  q2a;
        logic [1:0]  e_rdy;
        logic        e_we;
        logic [4:0]  e_a3;
        logic [31:0] e_wd;
        logic [31:0] e_busy;
        logic        e_q1;
        logic        e_q2;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic set_req(input logic [1:0] v, input logic [4:0] a0, input logic [4:0] a1,
                           input logic [31:0] d0, input logic [31:0] d1);
        req_valid = v;
        req_addr  = {a1, a0};
        req_data  = {d1, d0};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        rsv_valid = 1'b0;
        rsv_addr  = '0;
        q_a1      = '0;
        q_a2      = '0;
        set_req(2'b01, 5'd5, 5'd0, 32'h1, 32'h0);

        // Reset state, with a request already presented.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_we3", 32'(we3), 32'h0);
        chk("rst_a3", 32'(a3), 32'h0);
        chk("rst_wd3", wd3, 32'h0);
        chk("rst_busy", busy, 32'h0);
        set_req(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        rst_n = 1'b1;
        #1;

        //        v     a0     a1     d0            d1        rv    ra     q1a    q2a    rdy    we    a3     wd            busy          q1    q2
        tbl[0]  = '{2'b01, 5'd5,  5'd0, 32'hDEADBEEF, 32'h0,  1'b0, 5'd0,  5'd5,  5'd0,  2'b01, 1'b1, 5'd5,  32'hDEADBEEF, 32'h0,        1'b0, 1'b0};
        tbl[1]  = '{2'b01, 5'd3,  5'd0, 32'h33,       32'h0,  1'b0, 5'd0,  5'd0,  5'd0,  2'b01, 1'b1, 5'd3,  32'h33,       32'h0,        1'b0, 1'b0};
        tbl[2]  = '{2'b10, 5'd0,  5'd4, 32'h0,        32'h44, 1'b0, 5'd0,  5'd0,  5'd0,  2'b10, 1'b1, 5'd4,  32'h44,       32'h0,        1'b0, 1'b0};
        tbl[3]  = '{2'b00, 5'd0,  5'd0, 32'h0,        32'h0,  1'b0, 5'd0,  5'd0,  5'd0,  2'b00, 1'b0, 5'd4,  32'h44,       32'h0,        1'b0, 1'b0};
        tbl[4]  = '{2'b00, 5'd0,  5'd0, 32'h0,        32'h0,  1'b1, 5'd7,  5'd7,  5'd0,  2'b00, 1'b0, 5'd4,  32'h44,       32'h80,       1'b1, 1'b0};
        tbl[5]  = '{2'b01, 5'd7,  5'd0, 32'h77,       32'h0,  1'b0, 5'd0,  5'd7,  5'd0,  2'b01, 1'b1, 5'd7,  32'h77,       32'h0,        1'b0, 1'b0};
        tbl[6]  = '{2'b00, 5'd0,  5'd0, 32'h0,        32'h0,  1'b1, 5'd7,  5'd7,  5'd0,  2'b00, 1'b0, 5'd7,  32'h77,       32'h80,       1'b1, 1'b0};
        tbl[7]  = '{2'b10, 5'd0,  5'd7, 32'h0,        32'h78, 1'b1, 5'd7,  5'd7,  5'd7,  2'b10, 1'b1, 5'd7,  32'h78,       32'h80,       1'b1, 1'b1};
        tbl[8]  = '{2'b01, 5'd0,  5'd0, 32'h1234,     32'h0,  1'b1, 5'd0,  5'd0,  5'd7,  2'b01, 1'b0, 5'd7,  32'h78,       32'h80,       1'b0, 1'b1};
        tbl[9]  = '{2'b10, 5'd0,  5'd7, 32'h0,        32'h99, 1'b0, 5'd0,  5'd7,  5'd0,  2'b10, 1'b1, 5'd7,  32'h99,       32'h0,        1'b0, 1'b0};
        tbl[10] = '{2'b00, 5'd0,  5'd0, 32'h0,        32'h0,  1'b1, 5'd31, 5'd0,  5'd31, 2'b00, 1'b0, 5'd7,  32'h99,       32'h80000000, 1'b0, 1'b1};
        tbl[11] = '{2'b01, 5'd31, 5'd0, 32'hFFFF0000, 32'h0,  1'b0, 5'd0,  5'd0,  5'd31, 2'b01, 1'b1, 5'd31, 32'hFFFF0000, 32'h0,        1'b0, 1'b0};

        for (int i = 0; i < 12; i++) begin
            set_req(tbl[i].v, tbl[i].a0, tbl[i].a1, tbl[i].d0, tbl[i].d1);
            rsv_valid = tbl[i].rv;
            rsv_addr  = tbl[i].ra;
            q_a1      = tbl[i].q1a;
            q_a2      = tbl[i].q2a;
            #1;
            chk($sformatf("v%0d_ready", i), 32'(req_ready), 32'(tbl[i].e_rdy));
            step();
            chk($sformatf("v%0d_we3", i), 32'(we3), 32'(tbl[i].e_we));
            chk($sformatf("v%0d_a3", i), 32'(a3), 32'(tbl[i].e_a3));
            chk($sformatf("v%0d_wd3", i), wd3, tbl[i].e_wd);
            chk($sformatf("v%0d_busy", i), busy, tbl[i].e_busy);
            chk($sformatf("v%0d_qbusy1", i), 32'(q_busy1), 32'(tbl[i].e_q1));
            chk($sformatf("v%0d_qbusy2", i), 32'(q_busy2), 32'(tbl[i].e_q2));
        end
        set_req(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        rsv_valid = 1'b0;

        // Two simultaneous requesters from a fresh reset: r0 then r1.
        do_reset();
        set_req(2'b11, 5'd3, 5'd4, 32'h30, 32'h40);
        #1;
        chk("dual_ready0", 32'(req_ready), 32'h1);
        step();
        chk("dual_we_0", 32'(we3), 32'h1);
        chk("dual_a3_0", 32'(a3), 32'd3);
        set_req(2'b10, 5'd0, 5'd4, 32'h0, 32'h40);
        #1;
        chk("dual_ready1", 32'(req_ready), 32'h2);
        step();
        chk("dual_we_1", 32'(we3), 32'h1);
        chk("dual_a3_1", 32'(a3), 32'd4);
        chk("dual_wd3_1", wd3, 32'h40);
        set_req(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        step();
        chk("dual_we_idle", 32'(we3), 32'h0);

        // Both held valid for four cycles.
        set_req(2'b11, 5'd10, 5'd11, 32'hA0, 32'hB1);
        for (int c = 0; c < 4; c++) begin
            logic [1:0] er;
            logic [4:0] ea;
`ifdef RF_WB_RR_EN
            er = (c % 2 == 0) ? 2'b01 : 2'b10;
`else
            er = 2'b01;
`endif
            ea = er[0] ? 5'd10 : 5'd11;
            #1;
            chk($sformatf("hold%0d_ready", c), 32'(req_ready), 32'(er));
            step();
            chk($sformatf("hold%0d_a3", c), 32'(a3), 32'(ea));
        end
        set_req(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        step();

        // Reset asserted mid-burst; the held request is written exactly once afterwards.
        rsv_valid = 1'b1;
        rsv_addr  = 5'd12;
        step();
        rsv_valid = 1'b0;
        set_req(2'b01, 5'd9, 5'd0, 32'hAA, 32'h0);
        step();
        chk("mid_we3", 32'(we3), 32'h1);
        chk("mid_busy", busy, 32'h1000);
        set_req(2'b01, 5'd12, 5'd0, 32'hCC, 32'h0);
        rst_n = 1'b0;
        #1;
        chk("async_we3", 32'(we3), 32'h0);
        chk("async_busy", busy, 32'h0);
        chk("async_ready", 32'(req_ready), 32'h0);
        chk("async_a3", 32'(a3), 32'h0);
        step();
        rst_n = 1'b1;
        #1;
        chk("rel_ready", 32'(req_ready), 32'h1);
        step();
        chk("rel_we3", 32'(we3), 32'h1);
        chk("rel_a3", 32'(a3), 32'd12);
        chk("rel_wd3", wd3, 32'hCC);
        set_req(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        step();
        chk("rel_once", 32'(we3), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
